store_rmw_unit: RTL

- Store-side counterpart of the load-path extender: narrows a 32-bit register value to a byte or halfword and writes it into word-only data memory.
- SB/SH use read-modify-write (read word, merge lane, write word). SW writes directly.
- Sits between the datapath's store-issue logic and the data-memory port. It stalls the pipeline via busy.

---
 rtl/store_rmw_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/store_rmw_unit.sv
// Byte/halfword store via read-modify-write on a word-only data memory; SW writes straight through.
// Optional STORE_RMW_ALIGN_CHECK_EN rejects misaligned SH/SW; otherwise only op=11 is rejected.
module store_rmw_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_req,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rd_valid,
  output logic              mem_wr_req,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wr_ack
);

  localparam logic [1:0] OP_SW = 2'b00;
  localparam logic [1:0] OP_SH = 2'b01;
  localparam logic [1:0] OP_SB = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} state_t;

  state_t            state_q;
  logic              busy_q, done_q, err_q, mem_rd_req_q, mem_wr_req_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [1:0]        lane_q;
  logic              is_byte_q;
  logic [15:0]       wdata_q;
  logic              reject_d;
  logic [DATA_W-1:0] merged_d;

`ifdef STORE_RMW_ALIGN_CHECK_EN
  assign reject_d = (op == OP_RSV) || ((op == OP_SW) && (addr[1:0] != 2'b00)) ||
                    ((op == OP_SH) && addr[0]);
`else
  assign reject_d = (op == OP_RSV);
`endif

  // Per byte lane: take the stored byte/halfword if this lane is targeted, else keep memory data.
  for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic sel;
    assign sel = is_byte_q ? (lane_q == LANE) : (lane_q[1] == LANE[1]);
    assign merged_d[8*gi +: 8] = sel ? ((is_byte_q || !LANE[0]) ? wdata_q[7:0] : wdata_q[15:8])
                                     : mem_rdata[8*gi +: 8];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      mem_rd_req_q <= 1'b0;
      mem_wr_req_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      lane_q       <= 2'b00;
      is_byte_q    <= 1'b0;
      wdata_q      <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mem_addr_q <= {addr[ADDR_W-1:2], 2'b00};
            lane_q     <= addr[1:0];
            is_byte_q  <= (op == OP_SB);
            wdata_q    <= wdata[15:0];
            busy_q     <= 1'b1;
            if (reject_d) begin
              state_q <= ERR;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (op == OP_SW) begin
              state_q      <= WR;
              mem_wr_req_q <= 1'b1;
              mem_wdata_q  <= wdata;
            end else begin
              state_q      <= RD;
              mem_rd_req_q <= 1'b1;
            end
          end
        end
        RD: begin
          if (mem_rd_valid) begin
            state_q      <= WR;
            mem_rd_req_q <= 1'b0;
            mem_wr_req_q <= 1'b1;
            mem_wdata_q  <= merged_d;
          end
        end
        WR: begin
          if (mem_wr_ack) begin
            state_q      <= DONE;
            mem_wr_req_q <= 1'b0;
            done_q       <= 1'b1;
          end
        end
        DONE, ERR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_rd_req = mem_rd_req_q;
  assign mem_wr_req = mem_wr_req_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
